// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - RV32M divide encodings, widths and FSM state type
package div_sequencer_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_BUSY = 2'd1,
      DS_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - EX-stage fields in, stall/result out for the divider
interface div_sequencer_if;
   import div_sequencer_pkg::*;

   logic [6:0]      opcode_EX;
   logic [2:0]      funct3_EX;
   logic [6:0]      funct7_EX;
   logic [XLEN-1:0] rs1_data_EX;
   logic [XLEN-1:0] rs2_data_EX;
   logic            flush_EX;
   logic            stall_EX;
   logic            div_valid;
   logic [XLEN-1:0] result_EX;

   // pipeline side
   modport master (
      output opcode_EX, funct3_EX, funct7_EX, rs1_data_EX, rs2_data_EX, flush_EX,
      input  stall_EX, div_valid, result_EX
   );

   // divider side
   modport slave (
      input  opcode_EX, funct3_EX, funct7_EX, rs1_data_EX, rs2_data_EX, flush_EX,
      output stall_EX, div_valid, result_EX
   );

endinterface

// File: rtl/div_sequencer_div_step.sv
// rtl/div_sequencer_div_step.sv - one combinational restoring-division iteration
module div_step
   import div_sequencer_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] quo_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] quo_o
);

   logic [W:0] shifted;
   logic [W:0] diff;
   logic       ge;

   // rem_i < divisor always holds, so the trial difference fits in W bits
   // when there is no borrow and its top bit is a clean borrow flag
   always_comb begin
      shifted = {rem_i, quo_i[W-1]};
      diff    = shifted - {1'b0, divisor_i};
      ge      = ~diff[W];
      rem_o   = ge ? diff[W-1:0] : shifted[W-1:0];
      quo_o   = {quo_i[W-2:0], ge};
   end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU/REM/REMU controller for the EX stage
module div_sequencer
   import div_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   div_sequencer_if.slave ex
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [1:0] ST_IDLE = DS_IDLE;
   localparam logic [1:0] ST_BUSY = DS_BUSY;
   localparam logic [1:0] ST_DONE = DS_DONE;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  res_q, res_d;
   logic             neg_q, neg_d;
   logic             sel_rem_q, sel_rem_d;

   logic             is_div, is_signed, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0]  a_abs, b_abs, step_rem, step_quo, fin_val, fin_res;

   // decode and operand conditioning, only meaningful while IDLE
   always_comb begin
      is_div    = (ex.opcode_EX == OPC_RTYPE) && (ex.funct7_EX == F7_MULDIV) && ex.funct3_EX[2];
      is_signed = ~ex.funct3_EX[0];
      a_neg     = is_signed & ex.rs1_data_EX[XLEN-1];
      b_neg     = is_signed & ex.rs2_data_EX[XLEN-1];
      a_abs     = a_neg ? -ex.rs1_data_EX : ex.rs1_data_EX;
      b_abs     = b_neg ? -ex.rs2_data_EX : ex.rs2_data_EX;
      div_zero  = (ex.rs2_data_EX == '0);
      ovf       = is_signed && (ex.rs1_data_EX == INT_MIN) && (ex.rs2_data_EX == '1);
   end

   div_step #(.W(XLEN)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // final value is taken from the last step's output so DONE can present it directly
   always_comb begin
      fin_val = sel_rem_q ? step_rem : step_quo;
      fin_res = neg_q ? -fin_val : fin_val;
   end

   // FSM next state, operand latching and iteration datapath
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      res_d     = res_q;
      neg_d     = neg_q;
      sel_rem_d = sel_rem_q;
      case (state_q)
         ST_IDLE: begin
            if (is_div) begin
               dvs_d     = b_abs;
               quo_d     = a_abs;
               rem_d     = '0;
               cnt_d     = '0;
               sel_rem_d = ex.funct3_EX[1];
               neg_d     = ex.funct3_EX[1] ? a_neg : (a_neg ^ b_neg);
               if (div_zero) begin
                  // special results bypass the sign fix-up
                  res_d   = ex.funct3_EX[1] ? ex.rs1_data_EX : '1;
                  state_d = ST_DONE;
               end else if (ovf) begin
                  res_d   = ex.funct3_EX[1] ? '0 : INT_MIN;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               res_d   = fin_res;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // an aborted instruction must never leave a result behind
      if (ex.flush_EX) begin
         state_d = ST_IDLE;
         res_d   = res_q;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         res_q     <= '0;
         neg_q     <= 1'b0;
         sel_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         res_q     <= res_d;
         neg_q     <= neg_d;
         sel_rem_q <= sel_rem_d;
      end
   end

   // pipeline hold and result qualification
   always_comb begin
      ex.stall_EX  = ~ex.flush_EX & (((state_q == ST_IDLE) & is_div) | (state_q == ST_BUSY));
      ex.div_valid = ~ex.flush_EX & (state_q == ST_DONE);
      ex.result_EX = res_q;
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;
   import div_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   div_sequencer_if dif ();

   div_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .ex    (dif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_nop();
      dif.opcode_EX   = 7'd0;
      dif.funct3_EX   = 3'd0;
      dif.funct7_EX   = 7'd0;
      dif.rs1_data_EX = 32'd0;
      dif.rs2_data_EX = 32'd0;
      dif.flush_EX    = 1'b0;
   endtask

   task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      dif.opcode_EX   = OPC_RTYPE;
      dif.funct7_EX   = F7_MULDIV;
      dif.funct3_EX   = f3;
      dif.rs1_data_EX = a;
      dif.rs2_data_EX = b;
      dif.flush_EX    = 1'b0;
   endtask

   // called just after a rising edge; leaves the bench just after the edge ending DONE
   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
      int n = 0;
      int vseen = 0;
      set_op(f3, a, b);
      @(negedge clk);
      while (dif.stall_EX === 1'b1 && n < 100) begin
         if (dif.div_valid === 1'b1) vseen++;
         n++;
         @(negedge clk);
      end
      check({tag, "_stall"}, 32'(n), 32'(exp_stall));
      check({tag, "_early_valid"}, 32'(vseen), 32'd0);
      check({tag, "_valid"}, {31'd0, dif.div_valid}, 32'd1);
      check({tag, "_result"}, dif.result_EX, exp_res);
      @(posedge clk);
      #1;
      set_nop();
   endtask

   // start DIVU 100/7, abort after k edges by reset or flush, confirm nothing completes
   task automatic abort_op(input string tag, input bit use_reset, input int k);
      int vseen = 0;
      set_op(F3_DIVU, 32'd100, 32'd7);
      repeat (k) @(posedge clk);
      #1;
      if (use_reset) begin
         reset = 1'b1;
      end else begin
         dif.flush_EX = 1'b1;
         @(negedge clk);
         check({tag, "_flush_stall"}, {31'd0, dif.stall_EX}, 32'd0);
         check({tag, "_flush_valid"}, {31'd0, dif.div_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_nop();
      @(negedge clk);
      check({tag, "_next_stall"}, {31'd0, dif.stall_EX}, 32'd0);
      repeat (40) begin
         @(negedge clk);
         if (dif.div_valid === 1'b1 || dif.stall_EX === 1'b1) vseen++;
      end
      check({tag, "_quiet"}, 32'(vseen), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      set_nop();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_stall", {31'd0, dif.stall_EX}, 32'd0);
      check("reset_valid", {31'd0, dif.div_valid}, 32'd0);
      check("reset_result", dif.result_EX, 32'd0);
      @(posedge clk);
      #1;

      do_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
      do_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 33);
      do_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      do_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      do_op("rem_7_m2", F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      do_op("div_5_0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("remu_5_0", F3_REMU, 32'd5, 32'd0, 32'd5, 1);
      do_op("rem_m7_0", F3_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
      do_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      do_op("divu_nonovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      do_op("divu_max_1", F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      do_op("div_min_2", F3_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

      do_op("b2b_first", F3_DIVU, 32'd50, 32'd5, 32'd10, 33);
      do_op("b2b_second", F3_DIVU, 32'd9, 32'd3, 32'd3, 33);

      abort_op("reset_cnt10", 1'b1, 11);
      check("abort_reset_result", dif.result_EX, 32'd0);
      abort_op("flush_cnt5", 1'b0, 6);

      dif.opcode_EX = OPC_RTYPE;
      dif.funct7_EX = 7'd0;
      dif.funct3_EX = 3'd0;
      dif.rs1_data_EX = 32'd3;
      dif.rs2_data_EX = 32'd4;
      @(negedge clk);
      check("add_stall", {31'd0, dif.stall_EX}, 32'd0);
      @(posedge clk);
      #1;
      dif.funct3_EX = 3'b100;
      @(negedge clk);
      check("xor_stall", {31'd0, dif.stall_EX}, 32'd0);
      @(negedge clk);
      check("xor_valid", {31'd0, dif.div_valid}, 32'd0);
      @(posedge clk);
      #1;
      set_nop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
